// File: rtl/serial_pattern_detect_if.sv
// serial_pattern_detect_if: control, data and result bundle for the serial pattern detector
interface serial_pattern_detect_if #(parameter int PAT_W = 4, parameter int CNT_W = 8);
  logic en, dat_in, overlap, pat_load, clr_cnt, find;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] match_cnt;
  modport master(output en, dat_in, overlap, pat_load, pat_in, clr_cnt, input find, match_cnt);
  modport slave(input en, dat_in, overlap, pat_load, pat_in, clr_cnt, output find, match_cnt);
endinterface

// File: rtl/serial_pattern_detect.sv
// serial_pattern_detect: shift-window bit pattern matcher with hit pulse and saturating hit counter
module serial_pattern_detect #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1101)
) (
  input logic sys_clk,
  input logic rst,
  serial_pattern_detect_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] sh, pat, nxt;
  logic [FW-1:0] fill;
  logic [CNT_W-1:0] cnt;
  logic find_r, hit;
  assign nxt = {sh[PAT_W-2:0], bus.dat_in};
  assign hit = bus.en && !bus.pat_load && fill >= FW'(PAT_W - 1) && nxt == pat;
  assign bus.find = find_r;
  assign bus.match_cnt = cnt;
  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      sh <= '0;
      fill <= '0;
      pat <= DEF_PAT;
      find_r <= 1'b0;
      cnt <= '0;
    end else begin
      if (bus.pat_load) begin
        pat <= bus.pat_in;
        sh <= '0;
        fill <= '0;
      end else if (bus.en) begin
        sh <= nxt;
        fill <= (hit && !bus.overlap) ? '0 : (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
      end
      find_r <= hit;
      cnt <= bus.clr_cnt ? CNT_W'(hit) : (hit && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
    end
endmodule
